// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for the shared data memory.
// Each access takes IDLE -> ISSUE -> RESP; the owner is acked in RESP.
module dmem_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_ack,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_ack,
  output logic [31:0]       b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state, state_n;

  logic              last_b;
  logic              owner_b;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       a_rq;
  logic [31:0]       b_rq;
  logic              grant;
  logic              grant_b;

  // Upper address bits and byte offset are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{a_addr[31:ADDR_W+2], a_addr[1:0],
                         b_addr[31:ADDR_W+2], b_addr[1:0]};

  assign grant   = (state == IDLE) && (a_req || b_req);
  assign grant_b = b_req && (!a_req || !last_b);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (a_req || b_req) state_n = ISSUE;
      end
      ISSUE: begin
        state_n   = RESP;
        mem_en    = 1'b1;
        mem_we    = we_r;
        mem_addr  = addr_r;
        mem_wdata = wdata_r;
      end
      RESP: begin
        state_n = IDLE;
        a_ack   = !owner_b;
        b_ack   = owner_b;
      end
      default: state_n = IDLE;
    endcase
  end

  // Read data bypasses straight through in the ack cycle, then is held.
  assign a_rdata = (a_ack && !we_r) ? mem_rdata : a_rq;
  assign b_rdata = (b_ack && !we_r) ? mem_rdata : b_rq;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b  <= 1'b1;
      owner_b <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      a_rq    <= '0;
      b_rq    <= '0;
    end else begin
      if (grant) begin
        owner_b <= grant_b;
        last_b  <= grant_b;
        we_r    <= grant_b ? b_we : a_we;
        addr_r  <= grant_b ? b_addr[ADDR_W+1:2] : a_addr[ADDR_W+1:2];
        wdata_r <= grant_b ? b_wdata : a_wdata;
      end
      if (a_ack && !we_r) a_rq <= mem_rdata;
      if (b_ack && !we_r) b_rq <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural memory.
// Acks are checked by a monitor against a queue filled at request time.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, b_ack;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  logic [31:0] mem [4096];

  typedef struct {
    logic        port_b;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   a_acks = 0;
  int   b_acks = 0;

  localparam logic [31:0] W0 = 32'h1111_0000;
  localparam logic [31:0] W1 = 32'h2222_1111;
  localparam logic [31:0] W2 = 32'hA5A5_A5A5;
  localparam logic [31:0] W3 = 32'h5A5A_0003;
  localparam logic [31:0] W5 = 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Synchronous single-port memory: read data one cycle after strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every ack.
  always @(negedge clk) begin
    exp_t e;
    if (a_ack) a_acks++;
    if (b_ack) b_acks++;
    if (a_ack && b_ack) begin
      chk("both_acks", 32'd1, 32'd0);
    end else if (a_ack || b_ack) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", {31'd0, b_ack}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("ack_port", {31'd0, b_ack}, {31'd0, e.port_b});
        chk("ack_rdata", b_ack ? b_rdata : a_rdata, e.data);
      end
    end
  end

  task automatic drive(input bit pb, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (pb) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    end
  endtask

  // Single access from IDLE; returns at the next IDLE negedge.
  task automatic access(input bit pb, input bit we,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_data,
                        input logic [11:0] word);
    q.push_back('{port_b: pb, data: exp_data});
    drive(pb, 1'b1, we, addr, wd);
    @(negedge clk);
    chk("issue_en", {31'd0, mem_en}, 32'd1);
    chk("issue_we", {31'd0, mem_we}, {31'd0, we});
    chk("issue_addr", {20'd0, mem_addr}, {20'd0, word});
    if (we) chk("issue_wdata", mem_wdata, wd);
    @(negedge clk);
    chk("ack_latency", {31'd0, pb ? b_ack : a_ack}, 32'd1);
    drive(pb, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  // Both ports request together; acks expected every third cycle.
  task automatic tie(input int n_acc);
    int n0a, n0b;
    n0a = a_acks;
    n0b = b_acks;
    for (int k = 0; k < n_acc; k++)
      q.push_back('{port_b: (k % 2 == 1), data: (k % 2 == 1) ? W3 : W2});
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_000C, 32'd0);
    for (int i = 1; i <= 3 * n_acc - 1; i++) begin
      @(negedge clk);
      chk("tie_ack_slot", {31'd0, a_ack | b_ack},
          {31'd0, (i % 3 == 2)});
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("tie_a_count", a_acks - n0a, (n_acc + 1) / 2);
    chk("tie_b_count", b_acks - n0b, n_acc / 2);
  endtask

  initial begin
    int nb;
    mem[0] = W0;
    mem[1] = W1;
    mem[2] = W2;
    mem[3] = W3;
    mem[5] = W5;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    access(1'b0, 1'b0, 32'h0000_0014, 32'd0, W5, 12'd5);
    chk("t1_no_b_ack", b_acks, 0);

    access(1'b1, 1'b1, 32'h0000_3FFC, 32'h1234_5678, 32'd0, 12'hFFF);
    access(1'b1, 1'b0, 32'h0000_3FFC, 32'd0, 32'h1234_5678, 12'hFFF);
    access(1'b1, 1'b0, 32'h0000_7FFC, 32'd0, 32'h1234_5678, 12'hFFF);
    chk("t2_a_hold", a_rdata, W5);

    tie(4);

    q.push_back('{port_b: 1'b0, data: W0});
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'd0);
    repeat (2) @(negedge clk);
    chk("b2b_ack1", {31'd0, a_ack}, 32'd1);
    q.push_back('{port_b: 1'b0, data: W1});
    a_addr = 32'h0000_0004;
    repeat (3) @(negedge clk);
    chk("b2b_ack2", {31'd0, a_ack}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("b2b_a_rdata", a_rdata, W1);
    chk("b2b_b_hold", b_rdata, W3);

    drive(1'b0, 1'b1, 1'b0, 32'h0000_0014, 32'd0);
    @(negedge clk);
    chk("abort_in_issue", {31'd0, mem_en}, 32'd1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
    chk("abort_a_rdata", a_rdata, 32'd0);
    chk("abort_a_ack", {31'd0, a_ack}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    tie(2);

    nb = b_acks;
    q.push_back('{port_b: 1'b1, data: W5});
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0014, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("pulse_b_acks", b_acks - nb, 1);
    chk("pulse_b_rdata", b_rdata, W5);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the shared single-port data memory (4096 words × 32 bit) used by the memory-access stage. It lets port A (the core's load/store path) and port B (the debug/program-loader port) share one memory. It grants one requester at a time using round-robin priority and runs each access through a fixed three-state sequence. Each requester gets a single-cycle acknowledge pulse carrying read data.

## Interface
Parameters:
- ADDR_W, 12, memory word-address width; memory holds 2^ADDR_W words.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- a_req  in  1  port A request; held high until a_ack.
- a_we  in  1  port A write (1) / read (0); stable while a_req high.
- a_addr  in  32  port A byte address; word index = a_addr[ADDR_W+1:2].
- a_wdata  in  32  port A write data; stable while a_req high.
- a_ack  out  1  port A completion pulse, one cycle.
- a_rdata  out  32  port A read data; valid in the a_ack cycle.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid the cycle after a read strobe.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, ISSUE, RESP. Transitions:
  - IDLE→ISSUE when any request is high.
  - ISSUE→RESP unconditionally.
  - RESP→IDLE unconditionally.
- Arbitration happens only in IDLE:
  - Only one requester high: it wins.
  - Both high: the port not granted last wins.
  - last_grant resets to B, so port A wins the first tie after reset.
- On grant, register owner, we, word address (addr[ADDR_W+1:2]) and wdata. Requester inputs are ignored until the next IDLE.
- ISSUE:
  - mem_en=1, mem_we=registered we.
  - mem_addr and mem_wdata come from the registered values.
- RESP:
  - Owner's ack=1.
  - On reads, owner's rdata = mem_rdata, captured into an output register that holds until the next read completes for that port.
  - On writes, rdata is unchanged.
- Address bits above ADDR_W+1 and the byte offset bits [1:0] are ignored. There is no alignment fault.
- If a requester drops req after grant, the transaction still completes and ack still pulses.
- The owner's req is still high during its ack cycle and may stay high for the following IDLE cycle as a new request. Round-robin then gives the other port priority if it is requesting.
- Both acks are never high in the same cycle.

## Timing
- Reset values:
  - State IDLE, last_grant=B.
  - a_ack=b_ack=0, a_rdata=b_rdata=0.
  - mem_en=mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- mem_en, mem_we, mem_addr and mem_wdata are 0 outside ISSUE.
- Latency: request sampled high in IDLE at edge N → mem_en high cycle N+1 → ack high cycle N+2 → back in IDLE cycle N+3.
- Throughput: one access per 3 cycles. Two continuously requesting ports alternate A,B,A,B.
- Reset asserted in any state:
  - The next edge forces IDLE and clears all outputs.
  - An in-flight access is abandoned with no ack.
  - A write already strobed in ISSUE may have reached memory.

## Test plan
- Single read A: preload word 5 = 0xDEADBEEF, a_req with a_addr=0x14 → mem_en one cycle later with mem_addr=5, mem_we=0 → a_ack the next cycle with a_rdata=0xDEADBEEF; b_ack stays 0.
- Write then read B: b_we=1, b_addr=0x3FFC, b_wdata=0x12345678 → mem_addr=0xFFF, mem_we=1, b_ack two cycles after the request. A following read of 0x3FFC returns 0x12345678. b_addr=0x7FFC aliases to the same word.
- Simultaneous requests after reset: a_req and b_req rise together and stay high → grant order A,B,A,B, one ack every 3 cycles, never both acks in the same cycle.
- Back-to-back same port: a_req held high for two reads (addr 0x0 then 0x4) → two a_acks 3 cycles apart with correct data; b_rdata unchanged.
- Reset mid-access: assert reset in the ISSUE state of an A read → no a_ack; the next cycle shows busy=0, mem_en=0, a_rdata=0. After reset, a new tie grants A first.
- Request withdrawn: b_req pulsed for one cycle in IDLE → full sequence still runs and b_ack pulses once.
